regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter DATA_W, 32, register data width.
REQ-002 Parameter ADDR_W, 5, register index width (32 registers).
REQ-003 Parameter STARVE_MAX, 4, consecutive lost cycles before the load requester is forced to win; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 wb_valid / wb_ready  in / out  1 / 1  pipeline writeback request handshake.
REQ-007 wb_rd / wb_data  in  ADDR_W / DATA_W  writeback destination and value.
REQ-008 ld_valid / ld_ready  in / out  1 / 1  cache/memory load-return request handshake.
REQ-009 ld_rd / ld_data  in  ADDR_W / DATA_W  load-return destination and value.
REQ-010 rf_we / rf_waddr / rf_wdata  out  1 / ADDR_W / DATA_W  registered drive of the register file write port.
REQ-011 issue_valid / issue_rd  in  1 / ADDR_W  decode marks a destination as pending.
REQ-012 busy_mask  out  2**ADDR_W  per-register pending-write flags for hazard stall logic.

Function
REQ-013 A transfer on a requester occurs in a cycle where its valid and ready are both high; ready is a combinational function of both valids and arbiter state.
REQ-014 At most one of wb_ready, ld_ready is high in any cycle; ready is never high without its own valid.
REQ-015 Arbiter states: NORMAL, FORCE_LD.
REQ-016 NORMAL: wb wins if wb_valid; else ld wins if ld_valid.
REQ-017 Starve counter (4 bits): increments when ld_valid and ld loses; clears when ld transfers or ld_valid is low.
REQ-018 NORMAL -> FORCE_LD when the counter reaches STARVE_MAX; in FORCE_LD ld wins unconditionally if ld_valid.
REQ-019 FORCE_LD -> NORMAL on the cycle after the ld transfer, or immediately if ld_valid drops; counter clears on exit.
REQ-020 Latency: a transfer in cycle N drives rf_we=1 with that rd/data in cycle N+1 for exactly one cycle.
REQ-021 A transfer with rd==0 completes the handshake but rf_we stays 0 in cycle N+1 (r0 write discard).
REQ-022 With no transfer in cycle N, rf_we=0 in N+1; rf_waddr/rf_wdata hold their last value.
REQ-023 Both requesters valid with the same rd: the winner commits first, the loser in a later cycle; no merging.

Reset
REQ-024 rst_n low forces immediately: rf_we=0, rf_waddr=0, rf_wdata=0, state NORMAL, starve counter 0, busy_mask all-zero.
REQ-025 Reset asserted mid-transfer discards the pending write; no rf_we pulse follows reset release.
REQ-026 wb_ready and ld_ready are 0 while rst_n is low.

Configuration
REQ-027 Macro REGFILE_WR_ARBITER_SCOREBOARD_EN compiles the scoreboard in.
REQ-028 Defined: issue_valid sets busy_mask[issue_rd] (except rd 0) at posedge; a committed write (rf_we=1) clears busy_mask[rf_waddr]; set and clear of the same bit in one cycle: set wins.
REQ-029 Undefined: busy_mask is constant zero, issue inputs are ignored, no scoreboard flops exist.

Structure
REQ-030 Shared package holds the ADDR_W/DATA_W defaults, the arbiter state enum {NORMAL, FORCE_LD}, and the r0 index constant.
REQ-031 One sub-module, regfile_scoreboard, contains the busy_mask flops and is instantiated only under the macro.

Verification
REQ-032 Only wb_valid, rd=7, data=0xA5A5A5A5 -> wb_ready same cycle; next cycle rf_we=1, rf_waddr=7, rf_wdata=0xA5A5A5A5.
REQ-033 wb_valid and ld_valid held high 6 cycles, STARVE_MAX=4 -> wb wins cycles 0-3, ld wins cycle 4, wb wins cycle 5.
REQ-034 ld_valid, rd=0, data=0xFFFFFFFF -> ld_ready=1; next cycle rf_we=0.
REQ-035 Scoreboard on: issue rd=3 -> busy_mask=0x8; wb write rd=3 commits -> bit 3 clears the cycle after rf_we; simultaneous issue rd=3 and commit rd=3 -> bit stays 1.
REQ-036 rst_n pulsed low in the cycle after a wb transfer to rd=5 -> rf_we=0 immediately and after release; busy_mask=0; state NORMAL.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// rtl/regfile_wr_arbiter_pkg.sv - shared defaults, arbiter state encoding and r0 index
package regfile_wr_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned R0_IDX     = 0;
  localparam int unsigned STARVE_W   = 4;

  typedef enum logic {
    NORMAL   = 1'b0,
    FORCE_LD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - writeback and load-return request handshakes
//   master: drives wb_valid/wb_rd/wb_data, ld_valid/ld_rd/ld_data; samples wb_ready, ld_ready
//   slave : arbiter side, drives wb_ready, ld_ready
interface regfile_wr_arbiter_if
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output ld_valid, ld_rd, ld_data,
    input  wb_ready, ld_ready
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  ld_valid, ld_rd, ld_data,
    output wb_ready, ld_ready
  );

endinterface

// File: rtl/regfile_wr_arbiter_scoreboard.sv
// rtl/regfile_wr_arbiter_scoreboard.sv - per-register pending-write flags (module regfile_scoreboard)
//   clk, rst_n            : clock, asynchronous active-low reset
//   issue_valid, issue_rd : decode marks issue_rd pending
//   commit_we, commit_addr: registered register-file write port; clears the flag
//   busy_mask             : one pending flag per register
module regfile_scoreboard
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic                 commit_we,
  input  logic [ADDR_W-1:0]    commit_addr,
  output logic [2**ADDR_W-1:0] busy_mask
);

  logic [2**ADDR_W-1:0] busy_q;
  logic [2**ADDR_W-1:0] busy_d;

  // Clear is applied first so a same-cycle issue to the same register keeps it pending.
  always_comb begin
    busy_d = busy_q;
    if (commit_we) begin
      busy_d[commit_addr] = 1'b0;
    end
    if (issue_valid && (issue_rd != ADDR_W'(R0_IDX))) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_mask = busy_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester register-file write port arbiter with load anti-starvation
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req (slave)                 : writeback and load-return request handshakes
//   rf_we, rf_waddr, rf_wdata   : registered register-file write port, one cycle after transfer
//   issue_valid, issue_rd       : decode pending-destination marks
//   busy_mask                   : pending-write flags
//   REGFILE_WR_ARBITER_SCOREBOARD_EN: when defined, builds the busy_mask scoreboard
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wr_arbiter_if.slave  req,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  output logic [2**ADDR_W-1:0] busy_mask
);

  arb_state_e          state_q;
  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_inc;

  logic                wb_win;
  logic                ld_win;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;
  logic                commit;

  logic                rf_we_q,    rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

  // Grants are masked during reset so no handshake completes while rst_n is low.
  always_comb begin
    ld_win = 1'b0;
    wb_win = 1'b0;
    if (rst_n) begin
      ld_win = req.ld_valid && ((state_q == FORCE_LD) || !req.wb_valid);
      wb_win = req.wb_valid && !ld_win;
    end
  end

  assign req.wb_ready = wb_win;
  assign req.ld_ready = ld_win;

  assign starve_inc = starve_q + 1'b1;

  // FORCE_LD lasts one cycle: either the load transfers or it has dropped valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (req.ld_valid && !ld_win) begin
            starve_q <= starve_inc;
            if (starve_inc == STARVE_W'(STARVE_MAX)) begin
              state_q <= FORCE_LD;
            end
          end else begin
            starve_q <= '0;
          end
        end
        FORCE_LD: begin
          state_q  <= NORMAL;
          starve_q <= '0;
        end
      endcase
    end
  end

  assign sel_rd   = ld_win ? req.ld_rd   : req.wb_rd;
  assign sel_data = ld_win ? req.ld_data : req.wb_data;

  // Writes to r0 complete the handshake but never reach the register file.
  assign commit = (wb_win || ld_win) && (sel_rd != ADDR_W'(R0_IDX));

  always_comb begin
    rf_we_d    = commit;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (commit) begin
      rf_waddr_d = sel_rd;
      rf_wdata_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef REGFILE_WR_ARBITER_SCOREBOARD_EN
  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .commit_we   (rf_we_q),
    .commit_addr (rf_waddr_q),
    .busy_mask   (busy_mask)
  );
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_rd};
  assign busy_mask    = '0;
`endif

endmodule
